// File: rtl/proc6_ctrl.sv
// proc6_ctrl: instruction sequencer and 4x6-bit register file for the 6-bit
// simple processor. It fetches an instruction in T0 and executes mv/mvi in T1.
// add/sub run through T1..T3 using the external combinational add/sub unit.
// Done is decoded combinationally from state and IR. All other state is
// registered, and a synchronous active-high reset clears it.
module proc6_ctrl (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [5:0] DIN,
    output logic [5:0] AS_A,
    output logic [5:0] AS_B,
    output logic       AS_Ci,
    input  logic [5:0] AS_S,
    input  logic       AS_Co,
    output logic       Done,
    output logic [5:0] BusWires,
    output logic       C_flag,
    output logic       Z_flag,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;

    state_t     state;
    logic [5:0] ir;
    logic [5:0] regs [4];
    logic [5:0] a;
    logic [5:0] g;
    logic       c;
    logic       z;

    logic [1:0] op;
    logic [1:0] rx;
    logic [1:0] ry;

    assign op = ir[5:4];
    assign rx = ir[3:2];
    assign ry = ir[1:0];

    // The add/sub unit sees A and R[ry] at all times. It subtracts by
    // inverting B externally, and this carry-in supplies the +1.
    assign AS_A      = a;
    assign AS_B      = regs[ry];
    assign AS_Ci     = (op == OP_SUB);
    assign C_flag    = c;
    assign Z_flag    = z;
    assign dbg_state = state;

    // Done marks the cycle whose closing edge writes Rx.
    assign Done = ((state == T1) && ((op == OP_MV) || (op == OP_MVI))) ||
                  (state == T3);

    // Bus source selection by state and opcode. Every Rx write takes its value from the bus.
    always_comb begin
        BusWires = DIN;
        case (state)
            T0: BusWires = DIN;
            T1: begin
                case (op)
                    OP_MV:   BusWires = regs[ry];
                    OP_MVI:  BusWires = DIN;
                    default: BusWires = regs[rx];
                endcase
            end
            T2: BusWires = regs[ry];
            T3: BusWires = g;
            default: BusWires = DIN;
        endcase
    end

    // Sequencer and datapath registers. Reset takes priority over any pending write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
            ir    <= '0;
            a     <= '0;
            g     <= '0;
            c     <= 1'b0;
            z     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                T0: begin
                    if (Run) begin
                        ir    <= DIN;
                        state <= T1;
                    end
                end
                T1: begin
                    if ((op == OP_MV) || (op == OP_MVI)) begin
                        regs[rx] <= BusWires;
                        state    <= T0;
                    end else begin
                        a     <= BusWires;
                        state <= T2;
                    end
                end
                T2: begin
                    g     <= AS_S;
                    c     <= AS_Co;
                    z     <= (AS_S == 6'd0);
                    state <= T3;
                end
                T3: begin
                    regs[rx] <= BusWires;
                    state    <= T0;
                end
                default: state <= T0;
            endcase
        end
    end

endmodule

// File: tb/tb_proc6_ctrl.sv
// tb_proc6_ctrl: directed bench for proc6_ctrl. The bench models the 6-bit
// add/sub unit beside the DUT. It reads registers back by issuing mv Rk,Rk
// and observing the bus in T1.
module tb_proc6_ctrl;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic [5:0] DIN;
    logic [5:0] AS_A;
    logic [5:0] AS_B;
    logic       AS_Ci;
    logic [5:0] AS_S;
    logic       AS_Co;
    logic       Done;
    logic [5:0] BusWires;
    logic       C_flag;
    logic       Z_flag;
    logic [1:0] dbg_state;

    int checks;
    int errors;

    logic [5:0] bus_at [8];
    logic [5:0] t2_a;
    logic [5:0] t2_b;
    logic       t2_ci;
    logic [6:0] as_sum;

    proc6_ctrl dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Run      (Run),
        .DIN      (DIN),
        .AS_A     (AS_A),
        .AS_B     (AS_B),
        .AS_Ci    (AS_Ci),
        .AS_S     (AS_S),
        .AS_Co    (AS_Co),
        .Done     (Done),
        .BusWires (BusWires),
        .C_flag   (C_flag),
        .Z_flag   (Z_flag),
        .dbg_state(dbg_state)
    );

    // Clock and add/sub unit model: S = A + (Ci ? ~B : B) + Ci.
    always #5 Clock = ~Clock;
    assign as_sum = {1'b0, AS_A} + {1'b0, (AS_Ci ? ~AS_B : AS_B)} + {6'd0, AS_Ci};
    assign AS_S   = as_sum[5:0];
    assign AS_Co  = as_sum[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = 6'd0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // Issue one instruction from T0 and return the cycle index of Done (0 if none).
    task automatic run_instr(input logic [5:0] instr, input logic [5:0] imm, output int lat);
        lat = 0;
        Run = 1'b1;
        DIN = instr;
        @(posedge Clock);
        #1;
        Run = 1'b0;
        DIN = imm;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clock);
            bus_at[k] = BusWires;
            if (k == 2) begin
                t2_a  = AS_A;
                t2_b  = AS_B;
                t2_ci = AS_Ci;
            end
            if (Done) begin
                lat = k;
                break;
            end
            @(posedge Clock);
            #1;
        end
        checks++;
        if (lat == 0) begin
            $display("FAIL done_timeout instr=%h: no Done within 6 cycles", instr);
            errors++;
        end
        @(posedge Clock);
        #1;
    endtask

    // Read R[idx] by executing mv Ridx,Ridx and sampling the bus in T1.
    task automatic read_reg(input logic [1:0] idx, output logic [5:0] val);
        Run = 1'b1;
        DIN = {2'b00, idx, idx};
        @(posedge Clock);
        #1;
        Run = 1'b0;
        @(negedge Clock);
        val = BusWires;
        @(posedge Clock);
        #1;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        do_reset();
        DIN = 6'h2A;
        @(negedge Clock);
        checks++; if (dbg_state !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", dbg_state); errors++; end
        checks++; if (Done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", Done); errors++; end
        checks++; if (AS_A !== 6'd0 || AS_B !== 6'd0 || AS_Ci !== 1'b0) begin
            $display("FAIL reset_as got=%h/%h/%b exp=00/00/0", AS_A, AS_B, AS_Ci); errors++; end
        checks++; if (C_flag !== 1'b0 || Z_flag !== 1'b0) begin
            $display("FAIL reset_flags got=C%b Z%b exp=C0 Z0", C_flag, Z_flag); errors++; end
        checks++; if (BusWires !== 6'h2A) begin $display("FAIL reset_bus_t0 got=%h exp=2a", BusWires); errors++; end
        @(posedge Clock);
        #1;
        DIN = 6'd0;
    endtask

    task automatic test_mvi();
        int lat;
        logic [5:0] v;
        run_instr(6'h10, 6'd5, lat);
        checks++; if (lat !== 1) begin $display("FAIL mvi_latency got=%0d exp=1", lat); errors++; end
        checks++; if (bus_at[1] !== 6'd5) begin $display("FAIL mvi_bus_t1 got=%h exp=05", bus_at[1]); errors++; end
        read_reg(2'd0, v);
        checks++; if (v !== 6'd5) begin $display("FAIL mvi_r0 got=%0d exp=5", v); errors++; end
        checks++; if (C_flag !== 1'b0 || Z_flag !== 1'b0) begin
            $display("FAIL mvi_flags got=C%b Z%b exp=C0 Z0", C_flag, Z_flag); errors++; end
    endtask

    task automatic test_add();
        int lat;
        logic [5:0] v;
        run_instr(6'h14, 6'd3, lat);
        run_instr(6'h21, 6'd0, lat);
        checks++; if (lat !== 3) begin $display("FAIL add_latency got=%0d exp=3", lat); errors++; end
        checks++; if (t2_a !== 6'd5 || t2_b !== 6'd3 || t2_ci !== 1'b0) begin
            $display("FAIL add_t2_operands got=%0d/%0d/%b exp=5/3/0", t2_a, t2_b, t2_ci); errors++; end
        checks++; if (bus_at[1] !== 6'd5 || bus_at[2] !== 6'd3 || bus_at[3] !== 6'd8) begin
            $display("FAIL add_bus got=%0d/%0d/%0d exp=5/3/8", bus_at[1], bus_at[2], bus_at[3]); errors++; end
        read_reg(2'd0, v);
        checks++; if (v !== 6'd8) begin $display("FAIL add_r0 got=%0d exp=8", v); errors++; end
        checks++; if (C_flag !== 1'b0 || Z_flag !== 1'b0) begin
            $display("FAIL add_flags got=C%b Z%b exp=C0 Z0", C_flag, Z_flag); errors++; end
    endtask

    task automatic test_sub();
        int lat;
        logic [5:0] v;
        run_instr(6'h34, 6'd0, lat);
        checks++; if (t2_ci !== 1'b1 || t2_a !== 6'd3 || t2_b !== 6'd8) begin
            $display("FAIL sub_t2_operands got=%0d/%0d/%b exp=3/8/1", t2_a, t2_b, t2_ci); errors++; end
        read_reg(2'd1, v);
        checks++; if (v !== 6'd59) begin $display("FAIL sub_r1 got=%0d exp=59", v); errors++; end
        checks++; if (C_flag !== 1'b0 || Z_flag !== 1'b0) begin
            $display("FAIL sub_flags got=C%b Z%b exp=C0 Z0", C_flag, Z_flag); errors++; end
    endtask

    task automatic test_sub_self_and_mv();
        int lat;
        logic [5:0] v;
        run_instr(6'h18, 6'd17, lat);
        run_instr(6'h3A, 6'd0, lat);
        read_reg(2'd2, v);
        checks++; if (v !== 6'd0) begin $display("FAIL subself_r2 got=%0d exp=0", v); errors++; end
        checks++; if (C_flag !== 1'b1 || Z_flag !== 1'b1) begin
            $display("FAIL subself_flags got=C%b Z%b exp=C1 Z1", C_flag, Z_flag); errors++; end
        run_instr(6'h18, 6'd9, lat);
        run_instr(6'h0E, 6'd0, lat);
        checks++; if (lat !== 1) begin $display("FAIL mv_latency got=%0d exp=1", lat); errors++; end
        read_reg(2'd3, v);
        checks++; if (v !== 6'd9) begin $display("FAIL mv_r3 got=%0d exp=9", v); errors++; end
        checks++; if (C_flag !== 1'b1 || Z_flag !== 1'b1) begin
            $display("FAIL mv_flags_kept got=C%b Z%b exp=C1 Z1", C_flag, Z_flag); errors++; end
    endtask

    task automatic test_back_to_back();
        int lat;
        lat = 0;
        run_instr(6'h10, 6'd63, lat);
        run_instr(6'h14, 6'd1, lat);
        // Run stays high through the whole add and into the next fetch.
        Run = 1'b1;
        DIN = 6'h21;
        @(posedge Clock);
        #1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clock);
            if (Done) begin
                lat = k;
                break;
            end
            @(posedge Clock);
            #1;
        end
        checks++; if (lat !== 3) begin $display("FAIL b2b_add_latency got=%0d exp=3", lat); errors++; end
        @(posedge Clock);
        #1;
        DIN = 6'h08;
        @(negedge Clock);
        checks++; if (dbg_state !== 2'd0 || Done !== 1'b0) begin
            $display("FAIL b2b_t0 got=state%0d done%b exp=state0 done0", dbg_state, Done); errors++; end
        checks++; if (C_flag !== 1'b1 || Z_flag !== 1'b1) begin
            $display("FAIL wrap_flags got=C%b Z%b exp=C1 Z1", C_flag, Z_flag); errors++; end
        @(posedge Clock);
        #1;
        Run = 1'b0;
        @(negedge Clock);
        checks++; if (dbg_state !== 2'd1 || Done !== 1'b1 || BusWires !== 6'd0) begin
            $display("FAIL b2b_fetch got=state%0d done%b bus%0d exp=state1 done1 bus0",
                     dbg_state, Done, BusWires); errors++; end
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset_mid_instr();
        int lat;
        logic [5:0] v;
        run_instr(6'h10, 6'd5, lat);
        run_instr(6'h14, 6'd3, lat);
        Run = 1'b1;
        DIN = 6'h21;
        @(posedge Clock);
        #1;
        Run = 1'b0;
        @(posedge Clock);
        #1;
        @(negedge Clock);
        checks++; if (dbg_state !== 2'd2) begin $display("FAIL rst_pre_t2 got=%0d exp=2", dbg_state); errors++; end
        Reset = 1'b1;
        Run   = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        Run   = 1'b0;
        @(negedge Clock);
        checks++; if (dbg_state !== 2'd0 || Done !== 1'b0) begin
            $display("FAIL rst_mid_state got=state%0d done%b exp=state0 done0", dbg_state, Done); errors++; end
        checks++; if (C_flag !== 1'b0 || Z_flag !== 1'b0 || AS_A !== 6'd0) begin
            $display("FAIL rst_mid_clear got=C%b Z%b A%0d exp=C0 Z0 A0", C_flag, Z_flag, AS_A); errors++; end
        @(posedge Clock);
        #1;
        read_reg(2'd0, v);
        checks++; if (v !== 6'd0) begin $display("FAIL rst_mid_r0 got=%0d exp=0", v); errors++; end
        read_reg(2'd1, v);
        checks++; if (v !== 6'd0) begin $display("FAIL rst_mid_r1 got=%0d exp=0", v); errors++; end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        Clock  = 1'b0;
        Reset  = 1'b1;
        Run    = 1'b0;
        DIN    = 6'd0;
        test_reset();
        test_mvi();
        test_add();
        test_sub();
        test_sub_self_and_mv();
        test_back_to_back();
        test_reset_mid_instr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
